// File: rtl/svi_member_writer.sv
// svi_member_writer: FIFO-queued writer of members z/y/x with a per-command hold time.
// Optional registered parity output o_par when SVI_MEMBER_WRITER_PARITY_EN is defined.
module svi_member_writer #(
   parameter int DEPTH  = 4,
   parameter int HOLD_W = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [1:0]                 i_sel,
   input  logic                       i_data,
   input  logic [HOLD_W-1:0]          i_hold,
   output logic                       o_z,
   output logic                       o_y,
   output logic                       o_x,
`ifdef SVI_MEMBER_WRITER_PARITY_EN
   output logic                       o_par,
`endif
   output logic                       o_busy,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = 3 + HOLD_W;
   typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;
   state_t            state_q, state_d;
   logic [EW-1:0]     mem_q [DEPTH];
   logic [EW-1:0]     cmd_q, cmd_d;
   logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]     count_q, count_d;
   logic [HOLD_W-1:0] cnt_q, cnt_d;
   logic              z_q, z_d, y_q, y_d, x_q, x_d;
   logic              push, pop, apply;
   logic [1:0]        c_sel;
   logic              c_data;
   logic [HOLD_W-1:0] c_hold;
   assign {c_sel, c_data, c_hold} = cmd_q;
   always_ff @(posedge i_clk) state_q <= i_rst ? IDLE : state_d;
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = (count_q != '0) ? APPLY : IDLE;
         APPLY:   state_d = (c_hold == '0) ? IDLE : HOLD;
         HOLD:    state_d = (cnt_q == HOLD_W'(1)) ? IDLE : HOLD;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      o_busy = state_q != IDLE;
      pop    = state_q == IDLE && count_q != '0;
      apply  = state_q == APPLY;
   end
   assign o_ready = count_q != CW'(DEPTH);
   assign push    = i_valid && o_ready;
   always_comb begin
      wr_d    = push ? wr_q + AW'(1) : wr_q;
      rd_d    = pop ? rd_q + AW'(1) : rd_q;
      count_d = count_q + CW'(push) - CW'(pop);
      cmd_d   = pop ? mem_q[rd_q] : cmd_q;
      cnt_d   = apply ? c_hold : (state_q == HOLD ? cnt_q - HOLD_W'(1) : cnt_q);
      z_d     = (apply && (c_sel == 2'd0 || c_sel == 2'd3)) ? c_data : z_q;
      y_d     = (apply && (c_sel == 2'd1 || c_sel == 2'd3)) ? c_data : y_q;
      x_d     = (apply && (c_sel == 2'd2 || c_sel == 2'd3)) ? c_data : x_q;
   end
   always_ff @(posedge i_clk) if (push) mem_q[wr_q] <= {i_sel, i_data, i_hold};
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         cmd_q   <= '0;
         cnt_q   <= '0;
         z_q     <= 1'b0;
         y_q     <= 1'b0;
         x_q     <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         y_q     <= y_d;
         x_q     <= x_d;
      end
   end
`ifdef SVI_MEMBER_WRITER_PARITY_EN
   // Parity is taken from the next-state members so it lands on the same edge.
   logic par_q;
   always_ff @(posedge i_clk) par_q <= i_rst ? 1'b0 : z_d ^ y_d ^ x_d;
   assign o_par = par_q;
`endif
   assign o_z     = z_q;
   assign o_y     = y_q;
   assign o_x     = x_q;
   assign o_count = count_q;
endmodule

// File: tb/tb_svi_member_writer.sv
// tb_svi_member_writer: randomized and directed bench for svi_member_writer against a
// cycle-scheduled queue model of the command stream.
module tb_svi_member_writer;
   localparam int DEPTH  = 4;
   localparam int HOLD_W = 4;
   localparam int CW     = $clog2(DEPTH+1);
   logic clk = 1'b0;
   logic rst = 1'b1, valid = 1'b0, data = 1'b0;
   logic [1:0] sel = '0;
   logic [HOLD_W-1:0] hold = '0;
   logic ready, z, y, x, busy;
   logic [CW-1:0] count;
`ifdef SVI_MEMBER_WRITER_PARITY_EN
   logic par;
`endif
   int errs = 0, checks = 0;

   always #5 clk = ~clk;

   svi_member_writer #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
      .i_sel(sel), .i_data(data), .i_hold(hold),
      .o_z(z), .o_y(y), .o_x(x),
`ifdef SVI_MEMBER_WRITER_PARITY_EN
      .o_par(par),
`endif
      .o_busy(busy), .o_count(count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each popped command applies one edge later and keeps the writer busy
   // for 1+hold cycles; the next pop needs one idle cycle after that.
   typedef struct {logic [1:0] sel; logic data; int hold;} cmd_t;
   cmd_t q[$];
   cmd_t cur;
   int t = 0, apply_at = -1, busy_until = 0, idle_from = 0;
   logic mz = 0, my = 0, mx = 0, e_busy = 0, started = 0;
   always @(posedge clk) begin
      logic do_pop, do_push;
      if (rst) begin
         q.delete();
         {mz, my, mx} = 3'b000;
         apply_at = -1;
         busy_until = 0;
         idle_from = 0;
         started = 1;
      end else begin
         do_pop  = t >= idle_from && q.size() > 0;
         do_push = valid && q.size() != DEPTH;
         if (t == apply_at) begin
            if (cur.sel == 0 || cur.sel == 3) mz = cur.data;
            if (cur.sel == 1 || cur.sel == 3) my = cur.data;
            if (cur.sel == 2 || cur.sel == 3) mx = cur.data;
         end
         if (do_pop) begin
            cur = q.pop_front();
            apply_at = t + 1;
            busy_until = t + 1 + cur.hold;
            idle_from = t + 2 + cur.hold;
         end
         if (do_push) q.push_back('{sel, data, int'(hold)});
      end
      e_busy = t < busy_until;
      t++;
   end

   always @(negedge clk) if (started) begin
      check("z", z, mz);
      check("y", y, my);
      check("x", x, mx);
      check("busy", busy, e_busy);
      check("count", count, q.size());
      check("ready", ready, q.size() != DEPTH);
`ifdef SVI_MEMBER_WRITER_PARITY_EN
      check("par", par, mz ^ my ^ mx);
`endif
   end

   // Called just after a negedge; returns just after the negedge following acceptance.
   task automatic send(input logic [1:0] s, input logic d, input int h);
      int n = 0;
      logic acc;
      valid = 1'b1; sel = s; data = d; hold = HOLD_W'(h);
      do begin
         acc = ready;
         @(negedge clk);
         n++;
      end while (!acc && n < 200);
      valid = 1'b0;
      if (!acc) check("send_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || count != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) check("idle_timeout", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      int bc;
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);
      check("rst_members", {z, y, x}, 0);
      rst = 1'b0;
      // single y write, hold 0: visible two edges after acceptance
      send(1, 1, 0);
      check("lat_n_count", count, 1);
      check("lat_n_busy", busy, 0);
      @(negedge clk);
      check("lat_n1_busy", busy, 1);
      check("lat_n1_y", y, 0);
      @(negedge clk);
      check("lat_n2_y", y, 1);
      check("lat_n2_busy", busy, 0);
      check("lat_n2_zx", {z, x}, 0);
      wait_idle();
      // broadcast with hold 3
      send(3, 1, 3);
      bc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy) bc++;
      end
      check("hold3_busy_cycles", bc, 4);
      check("hold3_members", {z, y, x}, 3'b111);
      // fill the FIFO behind a long command
      for (int i = 0; i < 5; i++) send(2'(i & 1), 1'(i & 1), 5);
      check("full_count", count, 4);
      check("full_ready", ready, 0);
      send(2, 0, 5);
      wait_idle();
      // reset during HOLD with two queued
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      send(2, 1, 7);
      send(0, 1, 0);
      send(1, 1, 0);
      check("pre_rst_busy", busy, 1);
      check("pre_rst_count", count, 2);
      check("pre_rst_x", x, 1);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      check("post_rst_members", {z, y, x}, 0);
      check("post_rst_count", count, 0);
      check("post_rst_ready", ready, 1);
      repeat (20) @(negedge clk);
      check("no_stale_apply", {z, y, x}, 0);
      // nine alternating commands across pointer wrap
      for (int i = 0; i < 9; i++) send((i % 2) ? 2'd2 : 2'd0, (i % 2) ? 1'b0 : 1'b1, 0);
      wait_idle();
      check("wrap_final", {z, y, x}, 3'b100);
`ifdef SVI_MEMBER_WRITER_PARITY_EN
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      send(0, 1, 0);
      wait_idle();
      check("par_after_z", par, 1);
      send(1, 1, 0);
      wait_idle();
      check("par_after_y", par, 0);
`endif
      // random traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         rst   = ($urandom_range(0, 99) == 0);
         valid = $urandom_range(0, 1);
         sel   = 2'($urandom_range(0, 3));
         data  = 1'($urandom_range(0, 1));
         hold  = HOLD_W'($urandom_range(0, 3));
         @(negedge clk);
      end
      rst = 1'b0;
      valid = 1'b0;
      wait_idle();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/svi_member_writer.md
SVI_MEMBER_WRITER -- requirements
Module: svi_member_writer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving command FIFO entries; it must be a power of 2 and at least 2.
REQ-002 The module SHALL have parameter HOLD_W, default 4, giving the width of the per-command hold count.
REQ-003 The module SHALL have port i_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port i_rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The module SHALL have port i_valid, input, 1 bit: a write command is presented.
REQ-006 The module SHALL have port o_ready, output, 1 bit: the FIFO can accept a command.
REQ-007 The module SHALL have port i_sel, input, 2 bits: member select; 0 selects z, 1 selects y, 2 selects x, 3 selects all three.
REQ-008 The module SHALL have port i_data, input, 1 bit: the value to write to the selected member(s).
REQ-009 The module SHALL have port i_hold, input, HOLD_W bits: the number of HOLD cycles after the apply cycle.
REQ-010 The module SHALL have ports o_z, o_y and o_x, output, 1 bit each: the registered member values.
REQ-011 The module SHALL have port o_busy, output, 1 bit: asserted whenever the FSM is not in IDLE.
REQ-012 The module SHALL have port o_count, output, $clog2(DEPTH+1) bits: the FIFO occupancy.

Function
REQ-013 A command SHALL be accepted at an edge where i_valid and o_ready are both 1; the fields {i_sel, i_data, i_hold} are pushed into the FIFO.
REQ-014 o_ready SHALL equal (o_count != DEPTH), decoded combinationally from registered state.
REQ-015 The FSM SHALL have exactly three states: IDLE, APPLY and HOLD.
REQ-016 IDLE: when the FIFO is non-empty at an edge, the FSM SHALL pop the head into a command register and go to APPLY; otherwise it SHALL stay in IDLE.
REQ-017 APPLY: at the edge, the selected member(s) SHALL take the value of data and the hold counter SHALL load hold; the FSM SHALL go to IDLE if hold==0, otherwise to HOLD.
REQ-018 HOLD: the counter SHALL decrement each edge, and the FSM SHALL return to IDLE at the edge where the counter equals 1; HOLD therefore lasts exactly hold cycles.
REQ-019 Unselected members SHALL retain their values; writing the current value is legal and produces no change.
REQ-020 Latency: with the FSM in IDLE and the FIFO empty, a command accepted at edge N SHALL update the outputs at edge N+2; the FIFO has no bypass.
REQ-021 Throughput: hold=0 commands SHALL complete at one every 2 cycles; a command with hold=h SHALL occupy 2+h cycles.
REQ-022 A simultaneous push and pop SHALL leave o_count unchanged.
REQ-023 When full, o_ready SHALL be 0, and a pop SHALL reassert o_ready in the following cycle.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 A command presented while o_ready=0 SHALL be ignored; the sender must hold it.

Reset
REQ-026 While i_rst=1 at an edge, the state SHALL become IDLE, the FIFO SHALL become empty, the hold counter SHALL become 0, and o_z, o_y and o_x SHALL become 0.
REQ-027 After reset, o_ready SHALL be 1, o_busy SHALL be 0 and o_count SHALL be 0.
REQ-028 Reset during APPLY or HOLD SHALL abandon the command; queued commands are discarded and i_valid is ignored in that cycle.
REQ-029 Reset SHALL take priority over every other update.

Configuration
REQ-030 With SVI_MEMBER_WRITER_PARITY_EN defined, the module SHALL add output o_par, 1 bit, registered, equal to o_z^o_y^o_x; it updates in the same edge as the members and resets to 0.
REQ-031 Without SVI_MEMBER_WRITER_PARITY_EN defined, o_par and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then push {sel=1,data=1,hold=0} at edge N -> o_y=1 at edge N+2, o_z=o_x=0, o_busy=1 for exactly one cycle.
REQ-033 Push {sel=3,data=1,hold=3} -> all members become 1; o_busy is high for 4 cycles; the next queued command is popped only after that.
REQ-034 Hold i_valid high with hold=5 until the FIFO is full -> o_count=4, o_ready=0, and exactly 4 commands are accepted; the 5th is accepted the cycle after the first pop.
REQ-035 Push 9 commands alternating sel 0/2 and data 1/0 across pointer wrap -> outputs follow command order exactly, with no loss or duplication.
REQ-036 Assert i_rst during HOLD with 2 commands queued -> next cycle all outputs are 0, o_count=0, o_ready=1, and no queued command is applied afterwards.
REQ-037 With SVI_MEMBER_WRITER_PARITY_EN defined, write z=1 then y=1 -> o_par is 1 then 0, aligned with the member updates.
